// File: rtl/rr_grant_arbiter_pkg.sv
// Shared constants, state encoding and the rotating-priority helper
// for the round-robin grant arbiter.
package rr_grant_arbiter_pkg;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Returns the first requester with a set bit, scanning last_idx+1,
   // last_idx+2, ... and wrapping around to last_idx itself last. The scan
   // runs from the farthest candidate towards the nearest so that the
   // nearest hit overwrites the others. If req is all zeros the result
   // is last_idx, which the caller ignores.
   function automatic logic [IDX_W-1:0] next_idx(
      input logic [NUM_REQ-1:0] req,
      input logic [IDX_W-1:0]   last_idx
   );
      logic [IDX_W-1:0] sel;
      logic [IDX_W-1:0] cand;
      sel = last_idx;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = last_idx + IDX_W'(k);
         if (req[cand]) begin
            sel = cand;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/rr_grant_arbiter_dec2to4_en.sv
// Combinational 2-to-4 decoder with enable. Turns the registered owner
// index and valid flag into the one-hot grant vector.
module dec2to4_en
   import rr_grant_arbiter_pkg::*;
(
   input  logic [IDX_W-1:0]   idx,
   input  logic               en,
   output logic [NUM_REQ-1:0] y
);

   // One-hot decode of idx, forced to zero when the grant is not active.
   always_comb begin
      y = '0;
      if (en) begin
         y[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for four requesters sharing one resource select.
// A grant is held until the owner pulses done, withdraws its request, or
// HOLD_MAX cycles have elapsed; there is always one idle cycle between
// grants so two owners never overlap.
module rr_grant_arbiter
   import rr_grant_arbiter_pkg::*;
#(
   parameter int HOLD_MAX = 8,
   parameter int CNT_W    = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] done,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_valid,
   output logic               busy
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [IDX_W-1:0] last_idx_q, last_idx_d;
   logic             release_now;

   // The owner gives up the resource on its own done pulse, on dropping
   // its request, or when the hold limit is reached; done bits of other
   // requesters are deliberately not looked at.
   always_comb begin
      release_now = done[idx_q] || !req[idx_q] || (hold_cnt_q == HOLD_LAST);
   end

   // State register; last_idx resets to 3 so requester 0 wins first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         valid_q    <= 1'b0;
         hold_cnt_q <= '0;
         last_idx_q <= IDX_W'(NUM_REQ - 1);
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         valid_q    <= valid_d;
         hold_cnt_q <= hold_cnt_d;
         last_idx_q <= last_idx_d;
      end
   end

   // Next-state logic: arbitrate from IDLE, release back to IDLE from GRANT.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (req != '0) begin
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (release_now) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs and bookkeeping: pick the owner, count hold cycles,
   // and remember the released owner so it ranks lowest next time.
   always_comb begin
      idx_d      = idx_q;
      valid_d    = valid_q;
      hold_cnt_d = hold_cnt_q;
      last_idx_d = last_idx_q;
      unique case (state_q)
         IDLE: begin
            if (req != '0) begin
               idx_d      = next_idx(req, last_idx_q);
               valid_d    = 1'b1;
               hold_cnt_d = '0;
            end
         end
         GRANT: begin
            if (release_now) begin
               valid_d    = 1'b0;
               hold_cnt_d = '0;
               last_idx_d = idx_q;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: begin
            valid_d    = 1'b0;
            hold_cnt_d = '0;
         end
      endcase
   end

   // Status outputs come straight from registered state.
   always_comb begin
      grant_idx   = idx_q;
      grant_valid = valid_q;
      busy        = (state_q == GRANT);
   end

   dec2to4_en u_dec (
      .idx (idx_q),
      .en  (valid_q),
      .y   (grant)
   );

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed testbench for rr_grant_arbiter with hand-computed expectations.
module tb_rr_grant_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] done;
   logic [3:0] grant;
   logic [1:0] grant_idx;
   logic       grant_valid;
   logic       busy;

   int checkCount;
   int passCount;

   rr_grant_arbiter #(.HOLD_MAX(8), .CNT_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .busy        (busy)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compares one observed value against its expectation and logs misses.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drives req/done, then advances one rising edge and settles 1 ns past it.
   task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d);
      req  = r;
      done = d;
      @(posedge clk);
      #1;
   endtask

   localparam logic [3:0] ROT_ORDER [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

   // Directed scenario sequence.
   initial begin
      checkCount = 0;
      passCount  = 0;
      rst  = 1'b1;
      req  = 4'b1111;
      done = 4'b0000;

      // Reset held with all requests pending.
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      checkOutput("rst_grant", grant, 4'b0000);
      checkOutput("rst_valid", grant_valid, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_idx", grant_idx, 2'd0);

      // First grant after reset goes to requester 0.
      rst = 1'b0;
      applyStimulus(4'b1111, 4'b0000);
      checkOutput("first_grant", grant, 4'b0001);
      checkOutput("first_idx", grant_idx, 2'd0);
      checkOutput("first_busy", busy, 1'b1);

      // Rotation: each owner releases with done on its second grant cycle.
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("rot%0d_c1", i), grant, ROT_ORDER[i]);
         applyStimulus(4'b1111, 4'b0000);
         checkOutput($sformatf("rot%0d_c2", i), grant, ROT_ORDER[i]);
         applyStimulus(4'b1111, ROT_ORDER[i]);
         checkOutput($sformatf("rot%0d_gap", i), grant, 4'b0000);
         checkOutput($sformatf("rot%0d_gapv", i), grant_valid, 1'b0);
         if (i < 4) begin
            applyStimulus(4'b1111, 4'b0000);
         end
      end

      // Hold timeout: lone requester 2 with no done gets 8 cycles, gap, 8 again.
      for (int round = 0; round < 2; round++) begin
         for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b0100, 4'b0000);
            checkOutput($sformatf("hold%0d_c%0d", round, k + 1), grant, 4'b0100);
         end
         applyStimulus(4'b0100, 4'b0000);
         checkOutput($sformatf("hold%0d_gap", round), grant, 4'b0000);
      end

      // No requests: stays idle; done while idle has no effect.
      applyStimulus(4'b0000, 4'b0000);
      checkOutput("idle_noreq", grant, 4'b0000);
      applyStimulus(4'b0000, 4'b0100);
      checkOutput("idle_done", grant, 4'b0000);
      checkOutput("idle_done_busy", busy, 1'b0);

      // Ignored done: non-owner done must not end the grant or reset the count.
      applyStimulus(4'b0100, 4'b0000);
      checkOutput("ign_c1", grant, 4'b0100);
      applyStimulus(4'b0100, 4'b1011);
      checkOutput("ign_c2", grant, 4'b0100);
      for (int k = 3; k <= 8; k++) begin
         applyStimulus(4'b0100, 4'b0000);
         checkOutput($sformatf("ign_c%0d", k), grant, 4'b0100);
      end
      applyStimulus(4'b0100, 4'b0000);
      checkOutput("ign_expire", grant, 4'b0000);

      // Bring priority pointer to 0 with a one-cycle grant of requester 0.
      applyStimulus(4'b0001, 4'b0000);
      checkOutput("pre_w_grant", grant, 4'b0001);
      applyStimulus(4'b0001, 4'b0001);
      checkOutput("pre_w_gap", grant, 4'b0000);

      // Request withdrawal: owner 1 drops its request after 3 cycles.
      applyStimulus(4'b1010, 4'b0000);
      checkOutput("wd_c1", grant, 4'b0010);
      checkOutput("wd_idx", grant_idx, 2'd1);
      applyStimulus(4'b1010, 4'b0000);
      checkOutput("wd_c2", grant, 4'b0010);
      applyStimulus(4'b1010, 4'b0000);
      checkOutput("wd_c3", grant, 4'b0010);
      applyStimulus(4'b1000, 4'b0000);
      checkOutput("wd_gap", grant, 4'b0000);
      checkOutput("wd_gap_idx", grant_idx, 2'd1);
      applyStimulus(4'b1000, 4'b0000);
      checkOutput("wd_next", grant, 4'b1000);
      checkOutput("wd_next_idx", grant_idx, 2'd3);

      // Asynchronous reset between edges while requester 3 owns the grant.
      #2;
      rst = 1'b1;
      #1;
      checkOutput("arst_grant", grant, 4'b0000);
      checkOutput("arst_valid", grant_valid, 1'b0);
      checkOutput("arst_busy", busy, 1'b0);
      rst = 1'b0;
      applyStimulus(4'b1001, 4'b0000);
      checkOutput("arst_regrant", grant, 4'b0001);
      checkOutput("arst_regrant_idx", grant_idx, 2'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
